// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencing controller.
// Imported by lr_shift_core and shift_seq_ctrl.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lr_shift_core.sv
// Enabled bidirectional shift register with parallel load.
// Load has priority over shift; left shifts MSB out, right shifts LSB out.
module lr_shift_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             msb_out,
    output logic             lsb_out
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would let one register see another's new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            if (dir == DIR_RIGHT) q <= {serial_in, q[WIDTH-1:1]};
            else                  q <= {q[WIDTH-2:0], serial_in};
        end
    end

    assign msb_out = q[WIDTH-1];
    assign lsb_out = q[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller: accepts a word, runs WIDTH shift cycles, returns the
// captured word. Optional macro SHIFT_PAUSE_EN adds a 'pause' input that stalls SHIFT.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
`ifdef SHIFT_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] rx_data
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic             accept;
    logic             stalled;
    logic             shift_go;
    logic [WIDTH-1:0] core_q;
    logic             core_msb, core_lsb;

`ifdef SHIFT_PAUSE_EN
    assign stalled = pause;
`else
    assign stalled = 1'b0;
`endif

    assign accept   = (state == IDLE) && start_valid;
    assign shift_go = (state == SHIFT) && !stalled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = SHIFT;
            SHIFT:   if (shift_go && cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (done_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter saturates at the last bit so it never wraps or exceeds WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dir_q <= DIR_LEFT;
        end else if (accept) begin
            cnt   <= '0;
            dir_q <= dir;
        end else if (shift_go && cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        start_ready = 1'b0;
        shift_en    = 1'b0;
        busy        = 1'b0;
        done_valid  = 1'b0;
        serial_out  = 1'b0;
        case (state)
            IDLE:  start_ready = 1'b1;
            SHIFT: begin
                shift_en   = shift_go;
                busy       = 1'b1;
                serial_out = (dir_q == DIR_RIGHT) ? core_lsb : core_msb;
            end
            DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
            end
            default: ;
        endcase
    end

    lr_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (load_data),
        .shift_en  (shift_go),
        .dir       (dir_q),
        .serial_in (serial_in),
        .q         (core_q),
        .msb_out   (core_msb),
        .lsb_out   (core_lsb)
    );

    assign rx_data = core_q;

endmodule
